f1_start_seq: RTL and testbench

Parametrised F1 start-light sequencer with lights-out delay and reaction timing. On a trigger it fills `N_LIGHTS` lamps one per `en` tick, holds all lamps lit for a variable delay, then extinguishes them. It then measures the driver's reaction time in clock cycles and flags a jump start. It sits between the tick generator/LFSR (which supply `en` and `rand_delay`) and the lamp/display drivers.

---
 rtl/f1_pkg.sv | 13 +
 rtl/f1_react_timer.sv | 49 ++++
 rtl/f1_start_seq.sv | 148 ++++++++++++++
 tb/tb_f1_start_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// f1_pkg: shared types for the F1 start-light sequencer.
//   f1_state_t : sequencer state encoding used by f1_start_seq.
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_OUT   = 3'd3,
        ST_FAULT = 3'd4
    } f1_state_t;

endpackage

// File: rtl/f1_react_timer.sv
// f1_react_timer: saturating reaction-time counter with capture.
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset, clears count, result and valid
//   clr_i   : clear the running count (has priority over inc_i)
//   inc_i   : increment the running count, saturating at all ones
//   cap_i   : copy the running count into time_o; valid_o pulses next cycle
//   cnt_o   : running count
//   time_o  : last captured count, held until the next capture
//   valid_o : one-cycle pulse after a capture
module f1_react_timer #(
    parameter int unsigned TIME_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              cap_i,
    output logic [TIME_W-1:0] cnt_o,
    output logic [TIME_W-1:0] time_o,
    output logic              valid_o
);

    logic [TIME_W-1:0] cnt_q;
    logic [TIME_W-1:0] time_q;
    logic              valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= cap_i;
            if (cap_i) begin
                time_q <= cnt_q;
            end
            if (clr_i) begin
                cnt_q <= '0;
            end else if (inc_i && (cnt_q != '1)) begin
                cnt_q <= cnt_q + TIME_W'(1);
            end
        end
    end

    assign cnt_o   = cnt_q;
    assign time_o  = time_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-light sequencer with lights-out delay and
// reaction timing.
//   clk         : clock (rising edge)
//   rst         : synchronous active-high reset
//   en          : sequencing tick, advances FILL and HOLD
//   trigger     : start request (IDLE/FAULT -> FILL)
//   react       : driver response
//   rand_delay  : hold length, sampled on FILL -> HOLD
//   data_out    : thermometer lamp pattern
//   lights_out  : pulse on the first OUT cycle
//   react_time  : last measured reaction time in clocks
//   react_valid : pulse when react_time updates
//   jump_start  : high while in FAULT
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int unsigned N_LIGHTS = 8,
    parameter int unsigned DELAY_W  = 7,
    parameter int unsigned TIME_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                react,
    input  logic [DELAY_W-1:0]  rand_delay,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                lights_out,
    output logic [TIME_W-1:0]   react_time,
    output logic                react_valid,
    output logic                jump_start
);

    localparam int unsigned K_W = $clog2(N_LIGHTS + 1);

    f1_state_t         state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DELAY_W-1:0] dly_q, dly_d;

    logic              tmr_clr, tmr_inc, tmr_cap;
    logic [TIME_W-1:0] tmr_cnt;
    logic [N_LIGHTS-1:0] fill_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dly_q   <= dly_d;
        end
    end

    // Lowest k lamps lit.
    always_comb begin
        fill_pat = '0;
        for (int unsigned i = 0; i < N_LIGHTS; i++) begin
            fill_pat[i] = (i < 32'(k_q));
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        dly_d      = dly_q;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        tmr_cap    = 1'b0;
        data_out   = '0;
        lights_out = 1'b0;
        jump_start = 1'b0;

        case (state_q)
            ST_FILL: begin
                data_out = fill_pat;
                if (react) begin
                    state_d = ST_FAULT;
                end else if (en) begin
                    if (k_q < K_W'(N_LIGHTS)) begin
                        k_d = k_q + K_W'(1);
                    end else begin
                        state_d = ST_HOLD;
                        dly_d   = rand_delay;
                    end
                end
            end

            ST_HOLD: begin
                data_out = '1;
                if (react) begin
                    state_d = ST_FAULT;
                end else if (en) begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - DELAY_W'(1);
                    end else begin
                        state_d = ST_OUT;
                        tmr_clr = 1'b1;
                    end
                end
            end

            ST_OUT: begin
                // Count is cleared on entry and saturates, so zero only
                // occurs on the first OUT cycle.
                lights_out = (tmr_cnt == '0);
                if (react) begin
                    tmr_cap = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_FAULT: begin
                data_out   = '1;
                jump_start = 1'b1;
                if (trigger) begin
                    state_d = ST_FILL;
                    k_d     = '0;
                end
            end

            // ST_IDLE and any unreachable encoding.
            default: begin
                if (trigger) begin
                    state_d = ST_FILL;
                    k_d     = '0;
                end
            end
        endcase
    end

    f1_react_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (tmr_clr),
        .inc_i   (tmr_inc),
        .cap_i   (tmr_cap),
        .cnt_o   (tmr_cnt),
        .time_o  (react_time),
        .valid_o (react_valid)
    );

endmodule

// File: tb/tb_f1_start_seq.sv
// tb_f1_start_seq: directed bench for f1_start_seq. Two instances share
// stimulus: u_dut (N_LIGHTS=4, TIME_W=16) and u_dut4 (N_LIGHTS=4, TIME_W=4)
// so reaction-time saturation can be observed alongside the wide counter.
module tb_f1_start_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        trigger;
    logic        react;
    logic [6:0]  rand_delay;

    logic [3:0]  data_out,    data_out4;
    logic        lights_out,  lights_out4;
    logic [15:0] react_time;
    logic [3:0]  react_time4;
    logic        react_valid, react_valid4;
    logic        jump_start,  jump_start4;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int f_cnt;

    logic [3:0] exp_fill [16] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3,
                                  4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF,
                                  4'hF, 4'hF, 4'hF, 4'h0};

    always #5 clk = ~clk;

    f1_start_seq #(
        .N_LIGHTS (4),
        .DELAY_W  (7),
        .TIME_W   (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .trigger     (trigger),
        .react       (react),
        .rand_delay  (rand_delay),
        .data_out    (data_out),
        .lights_out  (lights_out),
        .react_time  (react_time),
        .react_valid (react_valid),
        .jump_start  (jump_start)
    );

    f1_start_seq #(
        .N_LIGHTS (4),
        .DELAY_W  (7),
        .TIME_W   (4)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .trigger     (trigger),
        .react       (react),
        .rand_delay  (rand_delay),
        .data_out    (data_out4),
        .lights_out  (lights_out4),
        .react_time  (react_time4),
        .react_valid (react_valid4),
        .jump_start  (jump_start4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; trigger = 1'b0; react = 1'b0; rand_delay = 7'd0;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_lout", 32'(lights_out), 32'h0);
        chk("rst_jump", 32'(jump_start), 32'h0);
        chk("rst_rtime", 32'(react_time), 32'h0);
        chk("rst_valid", 32'(react_valid), 32'h0);
        rst = 1'b0;

        // react in IDLE is ignored
        react = 1'b1;
        tick();
        chk("idle_react_data", 32'(data_out), 32'h0);
        chk("idle_react_valid", 32'(react_valid), 32'h0);
        chk("idle_react_jump", 32'(jump_start), 32'h0);
        react = 1'b0;

        // Full sequence, en every cycle, rand_delay=2 (en on trigger cycle ignored)
        trigger = 1'b1; en = 1'b1; rand_delay = 7'd2;
        tick();
        chk("fill_k0", 32'(data_out), 32'h0);
        trigger = 1'b0;
        tick(); chk("fill_k1", 32'(data_out), 32'h1);
        tick(); chk("fill_k2", 32'(data_out), 32'h3);
        tick(); chk("fill_k3", 32'(data_out), 32'h7);
        f_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_out == 4'hF) f_cnt++;
        end
        chk("all_on_cycles", 32'(f_cnt), 32'd4);
        chk("out_data", 32'(data_out), 32'h0);
        chk("out_lout", 32'(lights_out), 32'h1);
        en = 1'b0;
        tick();
        chk("out_c1_lout", 32'(lights_out), 32'h0);
        tick(); tick(); tick(); tick();
        react = 1'b1;
        tick();
        chk("react5_time", 32'(react_time), 32'd5);
        chk("react5_valid", 32'(react_valid), 32'h1);
        chk("react5_data", 32'(data_out), 32'h0);
        chk("react5_time4", 32'(react_time4), 32'd5);
        react = 1'b0;
        tick();
        chk("react5_valid_drop", 32'(react_valid), 32'h0);
        chk("react5_hold", 32'(react_time), 32'd5);

        // Jump start during FILL at k=2
        trigger = 1'b1;
        tick();
        trigger = 1'b0; en = 1'b1;
        tick(); tick();
        chk("fault_pre_k2", 32'(data_out), 32'h3);
        react = 1'b1;
        tick();
        chk("fault_data", 32'(data_out), 32'hF);
        chk("fault_jump", 32'(jump_start), 32'h1);
        chk("fault_valid", 32'(react_valid), 32'h0);
        react = 1'b0; en = 1'b0;
        tick();
        chk("fault_stay", 32'(jump_start), 32'h1);
        chk("fault_rtime", 32'(react_time), 32'd5);
        trigger = 1'b1;
        tick();
        chk("refill_data", 32'(data_out), 32'h0);
        chk("refill_jump", 32'(jump_start), 32'h0);
        chk("refill_rtime", 32'(react_time), 32'd5);
        trigger = 1'b0;

        // en every 3rd cycle, rand_delay=0; currently FILL k=0
        rand_delay = 7'd0;
        f_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            en = (i % 3 == 0);
            tick();
            chk($sformatf("slow_%0d", i), 32'(data_out), 32'(exp_fill[i]));
            if (data_out == 4'hF) f_cnt++;
        end
        chk("slow_all_on", 32'(f_cnt), 32'd6);
        chk("slow_lout", 32'(lights_out), 32'h1);
        en = 1'b0; react = 1'b1;
        tick();
        chk("react0_time", 32'(react_time), 32'd0);
        chk("react0_valid", 32'(react_valid), 32'h1);
        react = 1'b0;

        // Saturation: no react for 20 clocks
        trigger = 1'b1;
        tick();
        trigger = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("sat_lout", 32'(lights_out), 32'h1);
        en = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        react = 1'b1;
        tick();
        chk("sat_time16", 32'(react_time), 32'd20);
        chk("sat_time4", 32'(react_time4), 32'd15);
        chk("sat_valid4", 32'(react_valid4), 32'h1);
        react = 1'b0;
        tick();

        // trigger held through FILL has no effect; reset in HOLD
        trigger = 1'b1; en = 1'b1; rand_delay = 7'd2;
        tick();
        chk("trg_fill_k0", 32'(data_out), 32'h0);
        tick(); chk("trg_fill_k1", 32'(data_out), 32'h1);
        tick(); chk("trg_fill_k2", 32'(data_out), 32'h3);
        tick(); tick(); tick();
        chk("hold_data", 32'(data_out), 32'hF);
        rst = 1'b1;
        tick();
        chk("rst_hold_data", 32'(data_out), 32'h0);
        chk("rst_hold_rtime", 32'(react_time), 32'h0);
        chk("rst_hold_jump", 32'(jump_start), 32'h0);
        rst = 1'b0; trigger = 1'b0; en = 1'b0;
        tick();
        chk("post_rst_idle", 32'(data_out), 32'h0);

        // Reset in OUT while react is pending
        trigger = 1'b1;
        tick();
        trigger = 1'b0; en = 1'b1; rand_delay = 7'd0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_out_lout", 32'(lights_out), 32'h1);
        en = 1'b0;
        tick(); tick();
        react = 1'b1; rst = 1'b1;
        tick();
        chk("rst_out_valid", 32'(react_valid), 32'h0);
        chk("rst_out_rtime", 32'(react_time), 32'h0);
        chk("rst_out_data", 32'(data_out), 32'h0);
        chk("rst_out_lout0", 32'(lights_out), 32'h0);
        rst = 1'b0; react = 1'b0;
        tick();
        chk("rst_out_idle", 32'(react_valid), 32'h0);
        chk("rst_out_idle_data", 32'(data_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
